// File: rtl/fft_peak_scan_ctrl.sv
// Per-frame spectral peak scanner: walks the magnitude RAM once per frame,
// tracks the strongest bin and reports it with a threshold/holdoff-gated hit.
module fft_peak_scan_ctrl #(
    parameter int WIDTH          = 1024,
    parameter int ADDR_W         = 10,
    parameter int RD_LAT         = 2,
    parameter int FREQ_SCALE     = 3,
    parameter int HOLDOFF_FRAMES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_ready,
    input  logic [9:0]        threshold,
    output logic [ADDR_W-1:0] mag_addr,
    input  logic [9:0]        mag_data,
    output logic              busy,
    output logic              peak_valid,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [12:0]       peak_freq,
    output logic [9:0]        peak_amp,
    output logic              hit,
    output logic              overrun
);

    localparam int                HO_W       = $clog2(HOLDOFF_FRAMES + 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

    state_t            state_r, state_s;
    logic [2:0]        drain_cnt_r;
    logic              pending_r;
    logic [HO_W-1:0]   holdoff_r;
    logic [RD_LAT-1:0] vld_pipe_r;
    logic [ADDR_W-1:0] bin_pipe_r [RD_LAT];
    logic [9:0]        run_amp_r;
    logic [ADDR_W-1:0] run_bin_r;

    logic              scan_start_s, report_s, fr_busy_s, hit_s;
    logic              tail_vld_s;
    logic [ADDR_W-1:0] tail_bin_s;
    logic [9:0]        cand_amp_s;
    logic [ADDR_W-1:0] cand_bin_s;
    logic [12:0]       cand_freq_s;

    // Next-state selection for the scan sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (frame_ready) state_s = SCAN;
                else             state_s = IDLE;
            end
            SCAN: begin
                if (mag_addr == LAST_ADDR) state_s = DRAIN;
                else                       state_s = SCAN;
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) state_s = REPORT;
                else                           state_s = DRAIN;
            end
            REPORT: begin
                // A frame arriving on the report cycle restarts directly.
                if (pending_r || frame_ready) state_s = SCAN;
                else                          state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    assign scan_start_s = (state_s == SCAN) && (state_r != SCAN);
    assign report_s     = (state_s == REPORT);
    assign fr_busy_s    = frame_ready && (state_r != IDLE);
    assign tail_vld_s   = vld_pipe_r[RD_LAT-1];
    assign tail_bin_s   = bin_pipe_r[RD_LAT-1];

    // Merge the returning sample into the running max; bin 0 always seeds it.
    always_comb begin
        cand_amp_s = run_amp_r;
        cand_bin_s = run_bin_r;
        if (tail_vld_s && ((tail_bin_s == {ADDR_W{1'b0}}) || (mag_data > run_amp_r))) begin
            cand_amp_s = mag_data;
            cand_bin_s = tail_bin_s;
        end else begin
            cand_amp_s = run_amp_r;
            cand_bin_s = run_bin_r;
        end
    end

    assign cand_freq_s = 13'(FREQ_SCALE) * 13'(cand_bin_s);
    assign hit_s       = (cand_amp_s >= threshold) && (holdoff_r == {HO_W{1'b0}});

    // Sequencer state, address generation and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            mag_addr    <= {ADDR_W{1'b0}};
            busy        <= 1'b0;
            drain_cnt_r <= 3'd0;
            pending_r   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != IDLE);
            overrun <= fr_busy_s && pending_r;
            case (state_s)
                SCAN:    mag_addr <= (state_r == SCAN) ? (mag_addr + ADDR_ONE) : {ADDR_W{1'b0}};
                DRAIN:   mag_addr <= mag_addr;
                default: mag_addr <= {ADDR_W{1'b0}};
            endcase
            if (state_r == DRAIN) drain_cnt_r <= drain_cnt_r + 3'd1;
            else                  drain_cnt_r <= 3'd0;
            if (state_r == REPORT) pending_r <= 1'b0;
            else if (fr_busy_s)    pending_r <= 1'b1;
            else                   pending_r <= pending_r;
        end
    end

    // Valid/bin tag pipeline matching the RAM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_pipe_r[i] <= 1'b0;
                bin_pipe_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            vld_pipe_r[0] <= (state_r == SCAN);
            bin_pipe_r[0] <= mag_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
                bin_pipe_r[i] <= bin_pipe_r[i-1];
            end
        end
    end

    // Running maximum, cleared at the start of every scan.
    always_ff @(posedge clk) begin
        if (reset || scan_start_s) begin
            run_amp_r <= 10'd0;
            run_bin_r <= {ADDR_W{1'b0}};
        end else if (tail_vld_s) begin
            run_amp_r <= cand_amp_s;
            run_bin_r <= cand_bin_s;
        end else begin
            run_amp_r <= run_amp_r;
            run_bin_r <= run_bin_r;
        end
    end

    // Report registers and hit holdoff, updated as the last sample lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_valid <= 1'b0;
            peak_bin   <= {ADDR_W{1'b0}};
            peak_freq  <= 13'd0;
            peak_amp   <= 10'd0;
            hit        <= 1'b0;
            holdoff_r  <= {HO_W{1'b0}};
        end else if (report_s) begin
            peak_valid <= 1'b1;
            peak_bin   <= cand_bin_s;
            peak_freq  <= cand_freq_s;
            peak_amp   <= cand_amp_s;
            hit        <= hit_s;
            if (hit_s)                              holdoff_r <= HO_W'(HOLDOFF_FRAMES);
            else if (holdoff_r != {HO_W{1'b0}})     holdoff_r <= holdoff_r - HO_W'(1);
            else                                    holdoff_r <= holdoff_r;
        end else begin
            peak_valid <= 1'b0;
            hit        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_peak_scan_ctrl.sv
// Directed scoreboard bench for fft_peak_scan_ctrl (RD_LAT=2 and RD_LAT=4 instances).
module tb_fft_peak_scan_ctrl;

    typedef struct {
        int cyc;
        int bin;
        int amp;
        bit hit;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_ready = 1'b0;
    logic       fr4 = 1'b0;
    logic [9:0] threshold = 10'd600;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ho = 0;
    exp_t       sb_q[$];
    logic [9:0] mem [1024];

    logic [9:0]  mag_addr, mag_addr4;
    logic [9:0]  mag_data, mag_data4;
    logic        busy, peak_valid, hit, overrun;
    logic        busy4, peak_valid4, hit4, overrun4;
    logic [9:0]  peak_bin, peak_amp, peak_bin4, peak_amp4;
    logic [12:0] peak_freq, peak_freq4;
    logic [9:0]  ra1, ra2, rb1, rb2, rb3, rb4;

    fft_peak_scan_ctrl u_dut (
        .clk(clk), .reset(reset), .frame_ready(frame_ready), .threshold(threshold),
        .mag_addr(mag_addr), .mag_data(mag_data), .busy(busy), .peak_valid(peak_valid),
        .peak_bin(peak_bin), .peak_freq(peak_freq), .peak_amp(peak_amp),
        .hit(hit), .overrun(overrun)
    );

    fft_peak_scan_ctrl #(.RD_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset), .frame_ready(fr4), .threshold(threshold),
        .mag_addr(mag_addr4), .mag_data(mag_data4), .busy(busy4), .peak_valid(peak_valid4),
        .peak_bin(peak_bin4), .peak_freq(peak_freq4), .peak_amp(peak_amp4),
        .hit(hit4), .overrun(overrun4)
    );

    always #5 clk = ~clk;

    // Cycle counter plus two RAM read pipelines (latency 2 and 4).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ra1 <= mem[mag_addr];
        ra2 <= ra1;
        rb1 <= mem[mag_addr4];
        rb2 <= rb1;
        rb3 <= rb2;
        rb4 <= rb3;
    end
    assign mag_data  = ra2;
    assign mag_data4 = rb4;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic fill(input int val);
        for (int i = 0; i < 1024; i++) mem[i] = 10'(val);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ho = 0;
    endtask

    // Reference: first strongest bin, threshold and 4-frame holdoff.
    task automatic model_push(input int at);
        exp_t e;
        int   bb;
        int   ba;
        bb = 0;
        ba = int'(mem[0]);
        for (int i = 1; i < 1024; i++) begin
            if (int'(mem[i]) > ba) begin
                ba = int'(mem[i]);
                bb = i;
            end
        end
        e.cyc = at;
        e.bin = bb;
        e.amp = ba;
        e.hit = (ba >= int'(threshold)) && (ho == 0);
        if (e.hit) ho = 4;
        else if (ho > 0) ho--;
        sb_q.push_back(e);
    endtask

    task automatic check_report(input string tag, input exp_t e);
        chk({tag, ".cycle"}, cyc, e.cyc);
        chk({tag, ".bin"}, peak_bin, e.bin);
        chk({tag, ".freq"}, peak_freq, 3 * e.bin);
        chk({tag, ".amp"}, peak_amp, e.amp);
        chk({tag, ".hit"}, hit, e.hit);
    endtask

    task automatic run_frame(input string tag, output logic obs_hit);
        int   t;
        bit   got;
        exp_t e;
        t = cyc;
        model_push(t + 1027);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk({tag, ".busy_rise"}, busy, 1);
        chk({tag, ".addr0"}, mag_addr, 0);
        got = 1'b0;
        for (int i = 0; i < 1100 && !got; i++) begin
            if (peak_valid) got = 1'b1;
            else tick();
        end
        chk({tag, ".got_peak"}, got, 1);
        e = sb_q.pop_front();
        check_report(tag, e);
        obs_hit = hit;
        tick();
        chk({tag, ".busy_fall"}, busy, 0);
    endtask

    initial begin
        logic [5:0] hv;
        logic       h;
        int         t, c, n_pv, n_ov, ov_at, pk_at, addr_bad;
        exp_t       e;

        fill(5);
        do_reset();
        chk("rst.busy", busy, 0);
        chk("rst.addr", mag_addr, 0);
        chk("rst.pv", peak_valid, 0);
        chk("rst.peak", {peak_bin, peak_amp, peak_freq}, 0);
        chk("rst.hit_ovr", {hit, overrun}, 0);

        threshold = 10'd600;
        mem[341] = 10'd700;
        run_frame("single", h);

        fill(5);
        mem[10] = 10'd900;
        mem[20] = 10'd900;
        run_frame("tie", h);

        fill(5);
        mem[1023] = 10'd800;
        run_frame("last_bin", h);

        fill(0);
        threshold = 10'd1;
        run_frame("zero", h);

        // Holdoff: from a clean holdoff, six frames hit on 1st and 6th only.
        do_reset();
        fill(5);
        mem[341] = 10'd700;
        threshold = 10'd600;
        hv = 6'd0;
        for (int f = 0; f < 6; f++) begin
            run_frame("holdoff", h);
            hv = {hv[4:0], h};
        end
        chk("holdoff.pattern", hv, 6'b100001);

        // Pending and overrun: frame_ready at T, T+100, T+200.
        t = cyc;
        model_push(t + 1027);
        model_push(t + 2054);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        n_pv = 0;
        n_ov = 0;
        ov_at = -1;
        for (c = 1; c <= 2060; c++) begin
            if (overrun) begin
                n_ov++;
                ov_at = c;
            end
            if (peak_valid) begin
                n_pv++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_report("pend", e);
                end
            end
            if (c == 1028) begin
                chk("pend.restart_busy", busy, 1);
                chk("pend.restart_addr", mag_addr, 0);
            end
            frame_ready = (c == 100 || c == 200);
            tick();
        end
        frame_ready = 1'b0;
        chk("pend.n_overrun", n_ov, 1);
        chk("pend.overrun_at", ov_at, 201);
        chk("pend.n_peak", n_pv, 2);
        sb_q.delete();

        // Reset in the middle of a scan abandons the frame.
        t = cyc;
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        for (c = 1; c < 500; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ho = 0;
        chk("midrst.busy", busy, 0);
        chk("midrst.addr", mag_addr, 0);
        chk("midrst.peak", {peak_bin, peak_amp, peak_freq}, 0);
        chk("midrst.flags", {peak_valid, hit, overrun}, 0);
        n_pv = 0;
        for (c = 501; c <= 1100; c++) begin
            if (peak_valid) n_pv++;
            tick();
        end
        chk("midrst.no_peak", n_pv, 0);
        run_frame("after_rst", h);

        // Read latency 4 instance: address walk and report timing.
        fill(5);
        mem[341] = 10'd700;
        threshold = 10'd600;
        fr4 = 1'b1;
        tick();
        fr4 = 1'b0;
        chk("lat4.busy_rise", busy4, 1);
        addr_bad = 0;
        pk_at = -1;
        for (c = 1; c <= 1040; c++) begin
            if (c <= 1024 && mag_addr4 !== 10'(c - 1)) addr_bad++;
            if (peak_valid4 && pk_at < 0) begin
                pk_at = c;
                chk("lat4.bin", peak_bin4, 341);
                chk("lat4.freq", peak_freq4, 1023);
                chk("lat4.amp", peak_amp4, 700);
                chk("lat4.hit", hit4, 1);
            end
            tick();
        end
        chk("lat4.addr_walk", addr_bad, 0);
        chk("lat4.peak_at", pk_at, 1029);
        chk("lat4.busy_fall", busy4, 0);
        chk("lat4.overrun", overrun4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_peak_scan_ctrl.md
# fft_peak_scan_ctrl

Sequencer for per-frame spectral peak detection in the drum-trigger path. When the FFT magnitude buffer signals a completed frame, the block walks every bin address of that RAM and absorbs its pipelined read latency. It tracks the strongest bin and reports bin, frequency (3 × bin) and amplitude once per frame. It also gates drum hits with an amplitude threshold and a frame-count holdoff, replacing free-running hcount-driven peak tracking in the graphics/audio path.

## Interface
Parameters:
- WIDTH, 1024: number of bins scanned per frame (addresses 0..WIDTH-1)
- ADDR_W, 10: magnitude RAM address width; 2^ADDR_W ≥ WIDTH
- RD_LAT, 2: magnitude RAM read latency in cycles (1..4)
- FREQ_SCALE, 3: frequency per bin; FREQ_SCALE*(WIDTH-1) < 8192
- HOLDOFF_FRAMES, 4: reports suppressed after a hit

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- frame_ready  in  1  one-cycle pulse: new magnitude frame complete
- threshold  in  10  minimum peak_amp for a hit; sampled on the report cycle
- mag_addr  out  ADDR_W  magnitude RAM read address
- mag_data  in  10  magnitude RAM read data, valid RD_LAT cycles after address
- busy  out  1  scan in progress (SCAN, DRAIN, REPORT)
- peak_valid  out  1  one-cycle pulse: peak outputs updated
- peak_bin  out  ADDR_W  index of strongest bin
- peak_freq  out  13  FREQ_SCALE*peak_bin, zero-extended
- peak_amp  out  10  magnitude of strongest bin
- hit  out  1  one-cycle pulse coincident with qualifying peak_valid
- overrun  out  1  one-cycle pulse: a frame_ready was dropped

## Operation
- States: IDLE, SCAN, DRAIN, REPORT.
- IDLE: mag_addr = 0. On frame_ready, go to SCAN and clear the running max (amp 0, bin 0).
- SCAN: issue one address per cycle, 0 through WIDTH-1. After issuing WIDTH-1, go to DRAIN.
- DRAIN: stays RD_LAT cycles while the remaining data returns; mag_addr holds WIDTH-1.
- Compare stage: a valid-tag shift register (RD_LAT deep) aligns each returned mag_data with its bin index.
  - Update the running max only when mag_data > running amp (strictly greater). Ties keep the lowest bin.
  - Bin 0 is always loaded unconditionally.
- REPORT (one cycle):
  - Register peak_bin, peak_amp and peak_freq = FREQ_SCALE*bin. The product is exact with no truncation under the parameter rule.
  - Pulse peak_valid.
  - Next state is SCAN if pending is set (pending clears, running max clears), else IDLE.
- frame_ready while busy:
  - If pending = 0, set pending.
  - If pending = 1, pulse overrun the next cycle and drop the frame.
  - frame_ready on the REPORT cycle counts as busy.
- Hit logic on the REPORT cycle:
  - hit = (peak_amp_new ≥ threshold) && (holdoff == 0). peak_amp_new is the value being registered.
  - If hit, load holdoff = HOLDOFF_FRAMES.
  - Else, if holdoff > 0, decrement it.
- peak_bin, peak_freq and peak_amp hold between reports.

## Timing
- Reset values: state IDLE, mag_addr 0, busy 0, peak_valid 0, peak_bin 0, peak_freq 0, peak_amp 0, hit 0, overrun 0. Internal: pending 0, holdoff 0, valid pipe cleared.
- frame_ready at cycle T (IDLE):
  - busy rises and mag_addr = 0 at T+1.
  - mag_addr = k at T+1+k.
  - Last data returns at T+WIDTH+RD_LAT.
  - peak_valid and hit at T+WIDTH+RD_LAT+1. Defaults give T+1027.
  - busy falls at T+WIDTH+RD_LAT+2, unless pending restarts the scan.
- Back-to-back pending: SCAN resumes the cycle after REPORT (mag_addr = 0). Period is WIDTH+RD_LAT+1 cycles.
- Reset mid-scan: everything returns to reset values on the next edge. No peak_valid is issued for the abandoned frame, and pending is lost.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Single peak: RAM holds 5 everywhere and 700 at bin 341; threshold 600; frame_ready at T -> at T+1027 peak_valid=1, peak_bin=341, peak_freq=1023, peak_amp=700, hit=1; busy low at T+1028.
- Ties and edges:
  - Equal 900 at bins 10 and 20 -> peak_bin=10.
  - Max only at bin 1023 -> peak_bin=1023, peak_freq=3069.
  - All-zero RAM -> bin 0, amp 0, hit=0 with threshold 1.
- Holdoff: five consecutive frames with peak 700, threshold 600 -> hit on frames 1 only. Frames 2–5 report peak_valid without hit (holdoff 4→0). A sixth frame hits again.
- Pending and overrun: frame_ready at T, T+100 and T+200 -> overrun pulse at T+201. The second scan starts at T+1028 (mag_addr=0). Exactly two peak_valid pulses, at T+1027 and T+2054.
- Read latency: RD_LAT=4 with the RAM model delaying 4 cycles -> peak at bin 341 reported correctly at T+1029. Bench checks mag_addr increments by 1 each SCAN cycle.
- Reset mid-scan: assert reset at T+500 for one cycle -> all outputs 0 at T+501 and no peak_valid through T+1100. A new frame_ready then reports normally.
